apb_slave_if: RTL and testbench

//  APB completer-side interface: accepts APB transfers from an APB requester and converts them into a

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_timeout_cnt.sv | 21 ++
 rtl/apb_slave_if.sv | 112 +++++++++++
 tb/tb_apb_slave_if.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding and width helpers for the APB completer slice
package apb_pkg;
   localparam int ST_IDLE = 0;
   localparam int ST_REQ  = 1;
   localparam int ST_RESP = 2;
   localparam int ST_W    = 3;
   typedef enum logic [ST_W-1:0] {
      IDLE = ST_W'(1 << ST_IDLE),
      REQ  = ST_W'(1 << ST_REQ),
      RESP = ST_W'(1 << ST_RESP)
   } state_t;
   function automatic int strb_w(input int dw);
      return dw / 8;
   endfunction
endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: saturating wait counter that flags when a local request has waited TIMEOUT_CYCLE cycles
// Ports: apb_clk_in/apb_rstn_in clock and async active-low reset; clear zeroes the count,
//        enable counts one waited cycle, expired is high once the count reaches TIMEOUT_CYCLE.
module apb_timeout_cnt #(
   parameter int TIMEOUT_CYCLE = 6
) (
   input  logic apb_clk_in,
   input  logic apb_rstn_in,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLE + 1);
   logic [CW-1:0] cnt;
   assign expired = cnt == CW'(TIMEOUT_CYCLE);
   // Holds at TIMEOUT_CYCLE instead of wrapping so expired stays asserted.
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in)
      if (!apb_rstn_in) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/apb_slave_if.sv
// apb_slave_if: APB completer that turns each transfer into one request/ready handshake on a local bus
// Ports: apb_* is the APB completer side (PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB in,
//        PRDATA/PREADY and optional PSLVERR out); other_* is the local side (sel/addr/write/wdata/strb
//        out, rdata/ready/error in); other_clk_out is apb_clk_in forwarded.
// Build option: define APB_SLVERR_EN for apb_slverr_out and the ADDR_LIMIT range check.
module apb_slave_if
   import apb_pkg::*;
#(
   parameter int APB_DATA_WIDTH = 32,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLE  = 6
`ifdef APB_SLVERR_EN
   , parameter logic [APB_ADDR_WIDTH-1:0] ADDR_LIMIT = 'h1000
`endif
) (
   input  logic                                  apb_clk_in,
   input  logic                                  apb_rstn_in,
   input  logic [APB_ADDR_WIDTH-1:0]             apb_addr_in,
   input  logic                                  apb_psel_in,
   input  logic                                  apb_penable_in,
   input  logic                                  apb_write_in,
   input  logic [APB_DATA_WIDTH-1:0]             apb_wdata_in,
   input  logic [strb_w(APB_DATA_WIDTH)-1:0]     apb_strb_in,
   output logic [APB_DATA_WIDTH-1:0]             apb_rdata_out,
   output logic                                  apb_ready_out,
`ifdef APB_SLVERR_EN
   output logic                                  apb_slverr_out,
`endif
   output logic                                  other_clk_out,
   output logic                                  other_sel_out,
   output logic [APB_ADDR_WIDTH-1:0]             other_addr_out,
   output logic                                  other_write_out,
   output logic [APB_DATA_WIDTH-1:0]             other_wdata_out,
   output logic [strb_w(APB_DATA_WIDTH)-1:0]     other_strb_out,
   input  logic [APB_DATA_WIDTH-1:0]             other_rdata_in,
   input  logic                                  other_ready_in,
   input  logic                                  other_error_in
);
   state_t state;
   logic   expired, setup, oor;
   assign other_clk_out = apb_clk_in;
   assign setup = apb_psel_in && !apb_penable_in;
`ifdef APB_SLVERR_EN
   logic err_q;
   assign oor = apb_addr_in >= ADDR_LIMIT;
   assign apb_slverr_out = err_q;
`else
   assign oor = 1'b0;
`endif
   apb_timeout_cnt #(.TIMEOUT_CYCLE(TIMEOUT_CYCLE)) u_tmo (
      .apb_clk_in (apb_clk_in),
      .apb_rstn_in(apb_rstn_in),
      .clear      (state != REQ),
      .enable     (state == REQ && !other_ready_in),
      .expired    (expired)
   );
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in)
      if (!apb_rstn_in) begin
         state           <= IDLE;
         apb_rdata_out   <= '0;
         apb_ready_out   <= 1'b0;
         other_sel_out   <= 1'b0;
         other_addr_out  <= '0;
         other_write_out <= 1'b0;
         other_wdata_out <= '0;
         other_strb_out  <= '0;
`ifdef APB_SLVERR_EN
         err_q           <= 1'b0;
`endif
      end else begin
         case (state)
            REQ:
               if (!apb_psel_in) begin
                  other_sel_out <= 1'b0;
                  state         <= IDLE;
               end else if (other_ready_in || expired) begin
                  // Ready beats a simultaneous timeout; errored, timed-out and write completions return 0.
                  other_sel_out <= 1'b0;
                  apb_ready_out <= 1'b1;
                  apb_rdata_out <= (other_ready_in && !other_write_out && !other_error_in) ? other_rdata_in : '0;
`ifdef APB_SLVERR_EN
                  err_q         <= !other_ready_in || other_error_in;
`endif
                  state         <= RESP;
               end
            // IDLE and RESP share setup acceptance so a back-to-back setup in RESP goes straight on.
            default: begin
               apb_ready_out <= 1'b0;
               apb_rdata_out <= '0;
`ifdef APB_SLVERR_EN
               err_q         <= 1'b0;
`endif
               state         <= IDLE;
               if (setup) begin
                  other_addr_out  <= apb_addr_in;
                  other_write_out <= apb_write_in;
                  other_wdata_out <= apb_write_in ? apb_wdata_in : '0;
                  other_strb_out  <= apb_write_in ? apb_strb_in : '0;
                  other_sel_out   <= !oor;
                  // Out-of-range addresses never reach the local side and answer with an error at once.
                  if (oor) begin
                     apb_ready_out <= 1'b1;
`ifdef APB_SLVERR_EN
                     err_q         <= 1'b1;
`endif
                     state         <= RESP;
                  end else state <= REQ;
               end
            end
         endcase
      end
endmodule

// File: tb/tb_apb_slave_if.sv
// tb_apb_slave_if: randomized self-checking bench for apb_slave_if against a transfer-level model
module tb_apb_slave_if;
   localparam int TO = 6;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0, prdata, o_addr, o_wdata, o_rdata = '0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, pready;
   logic [3:0]  pstrb = '0, o_strb;
   logic        o_clk, o_sel, o_write, o_ready = 1'b0, o_error = 1'b0;
   logic        outs_any;
   int          checks = 0, errors = 0;
`ifdef APB_SLVERR_EN
   logic pslverr;
   assign outs_any = |{prdata, pready, pslverr, o_sel, o_addr, o_write, o_wdata, o_strb};
`else
   assign outs_any = |{prdata, pready, o_sel, o_addr, o_write, o_wdata, o_strb};
`endif
   always #5 clk = ~clk;
   apb_slave_if dut (
      .apb_clk_in(clk), .apb_rstn_in(rstn), .apb_addr_in(paddr), .apb_psel_in(psel),
      .apb_penable_in(penable), .apb_write_in(pwrite), .apb_wdata_in(pwdata), .apb_strb_in(pstrb),
      .apb_rdata_out(prdata), .apb_ready_out(pready),
`ifdef APB_SLVERR_EN
      .apb_slverr_out(pslverr),
`endif
      .other_clk_out(o_clk), .other_sel_out(o_sel), .other_addr_out(o_addr), .other_write_out(o_write),
      .other_wdata_out(o_wdata), .other_strb_out(o_strb), .other_rdata_in(o_rdata),
      .other_ready_in(o_ready), .other_error_in(o_error)
   );

   // One APB transfer; the local side answers w cycles after other_sel_out rises (w > TO: never).
   task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd, input logic [3:0] sb,
                       input int w, input logic [31:0] rd, input logic er);
      logic oor, tmo, exp_err, done;
      logic [31:0] exp_rd;
      int exp_it, it;
      oor = 1'b0;
`ifdef APB_SLVERR_EN
      oor = a >= 32'h1000;
`endif
      tmo = !oor && w > TO;
      exp_it = oor ? 0 : (w < TO ? w : TO) + 1;
      exp_rd = (oor || wr || tmo || er) ? 32'h0 : rd;
      exp_err = oor || tmo || er;
      psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd; pstrb = sb;
      @(posedge clk); #1;
      penable = 1'b1;
      done = 1'b0;
      it = 0;
      while (!done && it <= TO + 3) begin
         if (pready === 1'b1) begin
            done = 1'b1;
            checks++; if (it != exp_it) begin errors++; $display("FAIL pready_cycle got %0d exp %0d addr %h", it, exp_it, a); end
            checks++; if (prdata !== exp_rd) begin errors++; $display("FAIL prdata got %h exp %h addr %h", prdata, exp_rd, a); end
            checks++; if (o_sel !== 1'b0) begin errors++; $display("FAIL sel_at_ready got %b exp 0", o_sel); end
`ifdef APB_SLVERR_EN
            checks++; if (pslverr !== exp_err) begin errors++; $display("FAIL pslverr got %b exp %b addr %h", pslverr, exp_err, a); end
`else
            if (exp_err) checks++;
`endif
         end else begin
            checks++; if (o_sel !== !oor) begin errors++; $display("FAIL sel_high got %b exp %b cyc %0d", o_sel, !oor, it); end
            if (it == 0 && !oor) begin
               checks++;
               if (o_addr !== a || o_write !== wr || o_wdata !== (wr ? wd : 32'h0) || o_strb !== (wr ? sb : 4'h0)) begin
                  errors++;
                  $display("FAIL fwd got %h/%b/%h/%h exp %h/%b/%h/%h", o_addr, o_write, o_wdata, o_strb,
                           a, wr, wr ? wd : 32'h0, wr ? sb : 4'h0);
               end
            end
            o_ready = o_sel && it == w; o_rdata = rd; o_error = er;
            @(posedge clk); #1;
            o_ready = 1'b0;
            it++;
         end
      end
      if (!done) begin errors++; $display("FAIL no_pready got none exp cycle %0d", exp_it); end
   endtask

   task automatic idle();
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      checks++; if (pready !== 1'b0) begin errors++; $display("FAIL pready_pulse got %b exp 0", pready); end
   endtask

   task automatic test_reset();
      #12;
      checks++; if (outs_any !== 1'b0) begin errors++; $display("FAIL reset_outs got %b exp 0", outs_any); end
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0); idle();
   endtask

   task automatic test_read_wait();
      xfer(32'h20, 1'b0, 32'h0, 4'h0, 3, 32'h12345678, 1'b0); idle();
   endtask

   task automatic test_timeout();
      xfer(32'h24, 1'b0, 32'h0, 4'h0, 100, 32'hCAFEF00D, 1'b0); idle();
      xfer(32'h28, 1'b0, 32'h0, 4'h0, TO, 32'h0BADCAFE, 1'b0); idle();
   endtask

   task automatic test_out_of_range();
      xfer(32'h1000, 1'b0, 32'h0, 4'h0, 0, 32'h55555555, 1'b0); idle();
      xfer(32'h1FFC, 1'b1, 32'hA5A5A5A5, 4'h3, 0, 32'h0, 1'b0); idle();
   endtask

   task automatic test_no_setup();
      psel = 1'b1; penable = 1'b1; paddr = 32'h30;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (o_sel !== 1'b0 || pready !== 1'b0) begin errors++; $display("FAIL no_setup got %b%b exp 00", o_sel, pready); end
      end
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic test_abort();
      psel = 1'b1; penable = 1'b0; paddr = 32'h40; pwrite = 1'b0;
      @(posedge clk); #1;
      checks++; if (o_sel !== 1'b1) begin errors++; $display("FAIL abort_sel_up got %b exp 1", o_sel); end
      psel = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++; if (o_sel !== 1'b0 || pready !== 1'b0) begin errors++; $display("FAIL abort got %b%b exp 00", o_sel, pready); end
      end
   endtask

   task automatic test_back_to_back();
      xfer(32'h50, 1'b1, 32'h11112222, 4'h5, 1, 32'h0, 1'b0);
      xfer(32'h54, 1'b1, 32'h33334444, 4'hA, 2, 32'h0, 1'b0);
      idle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         xfer($urandom_range(0, 32'h17FF) & 32'hFFFF_FFFC, 1'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, TO + 2), $urandom, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) idle();
      end
      idle();
   endtask

   task automatic test_reset_in_req();
      psel = 1'b1; penable = 1'b0; paddr = 32'h60; pwrite = 1'b1; pwdata = 32'h77; pstrb = 4'h1;
      @(posedge clk); #1;
      penable = 1'b1;
      checks++; if (o_sel !== 1'b1) begin errors++; $display("FAIL rst_req_sel got %b exp 1", o_sel); end
      #2 rstn = 1'b0;
      #1;
      checks++; if (outs_any !== 1'b0) begin errors++; $display("FAIL rst_async got %b exp 0", outs_any); end
      psel = 1'b0; penable = 1'b0;
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_timeout();
`ifdef APB_SLVERR_EN
      test_out_of_range();
`endif
      test_no_setup();
      test_abort();
      test_back_to_back();
      test_random();
      test_reset_in_req();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
